mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter sharing the processor's 64×32 unified memory between the instruction-fetch port and the data (load/store) port. It sits between the core and the memory array. It accepts one request at a time over a req/gnt handshake, drives the memory with registered control, and returns read data with fixed latency. It also exports a busy flag so the core can stall.

## Interface
- ADDR_W, 6, word-address width (64 words)
- DATA_W, 32, data width
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; hold with if_addr stable until if_gnt
- if_addr  in  ADDR_W  fetch word address
- if_gnt  out  1  one-cycle fetch grant pulse
- if_rvalid  out  1  one-cycle fetch data-valid pulse
- if_rdata  out  DATA_W  fetch data; mem_rdata when if_rvalid, else 0
- dm_req  in  1  data request; hold with dm_we/dm_addr/dm_wdata stable until dm_gnt
- dm_we  in  1  1 = store, 0 = load
- dm_addr  in  ADDR_W  data word address
- dm_wdata  in  DATA_W  store data
- dm_gnt  out  1  one-cycle data grant pulse
- dm_rvalid  out  1  one-cycle load data-valid pulse (never for stores)
- dm_rdata  out  DATA_W  load data; mem_rdata when dm_rvalid, else 0
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the mem_en cycle
- busy  out  1  high whenever state ≠ IDLE

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: if any req is asserted, select a winner and pulse its gnt combinationally. Register the winner's addr, we, and wdata into mem_addr/mem_we/mem_wdata. Register the winner's ID. Go to ACCESS. With no req, stay in IDLE.
- ACCESS: mem_en = 1 and the registered mem_* outputs are stable. For a read, go to RESP. For a write, go to IDLE; the write is complete.
- RESP: pulse rvalid for the recorded winner with rdata = mem_rdata. Go to IDLE.
- gnt is asserted only in IDLE, at most one gnt per cycle, and never to a port whose req is low.
- Requests arriving outside IDLE wait. The requester holds req; there is no queueing.
- Default arbitration: when both ports request, the data port wins.
- mem_wdata is zeroed on fetch grants. mem_we = 0 for all fetches.
- Reset values: state IDLE; mem_en, mem_we, mem_addr, mem_wdata, busy, if_gnt, dm_gnt, if_rvalid, dm_rvalid, if_rdata, dm_rdata all 0.
- Reset mid-operation: on the next edge the FSM returns to IDLE and any pending rvalid is dropped. mem_en is gated by !rst, so a write whose ACCESS cycle coincides with rst is never performed.

## Timing
- gnt in cycle N → mem_en in cycle N+1 → rvalid/rdata in cycle N+2.
- Reads occupy 3 cycles (IDLE, ACCESS, RESP); writes occupy 2 cycles (IDLE, ACCESS).
- Earliest next gnt after a read gnt is N+3; after a write gnt it is N+2.
- busy is high in N+1..N+2 for reads and in N+1 for writes.
- A requester may drop req in the cycle after its gnt. Holding req high requests again.

## Configuration
- ARB_ROUND_ROBIN_EN defined: ties use round-robin. A last_winner flop records the most recent grant and resets to DATA, so the first tie after reset goes to fetch. Each later tie goes to the port that did not win last. A single requester always wins regardless of last_winner.
- ARB_ROUND_ROBIN_EN undefined: fixed data-port priority, and no last_winner flop exists.

## Structure
- Package mem_arb_pkg holds:
  - ADDR_W/DATA_W defaults
  - the state enum (IDLE, ACCESS, RESP)
  - port-ID constants PORT_IF and PORT_DM
- Sub-module mem_arb_pick is the combinational winner selector. Inputs: if_req, dm_req, last_winner. Outputs: grant_if and grant_dm. It contains the ARB_ROUND_ROBIN_EN conditional.

## Test plan
- Fetch only: if_req with if_addr=5 and mem[5]=0xDEADBEEF → if_gnt at N, mem_en/mem_addr=5 at N+1, if_rvalid with if_rdata=0xDEADBEEF at N+2, busy=1 for N+1..N+2.
- Store then load: dm_we=1, dm_addr=10, dm_wdata=0x12345678 → mem_we=1 at N+1 and no dm_rvalid. Then load addr 10 → dm_rdata=0x12345678 two cycles after its gnt.
- Simultaneous req (fetch addr 0, load addr 1), macro off → dm_gnt first, then if_gnt in the cycle after dm_rvalid. Repeated ties always favour data.
- Simultaneous req, ARB_ROUND_ROBIN_EN on, both held for 4 grants → grant order IF, DM, IF, DM.
- Reset during ACCESS of a store to addr 3 (old value 0xAAAA0000) → mem_en stays 0 that cycle, mem[3] is still 0xAAAA0000, state is IDLE and all outputs are 0 the next cycle.
- req held through a busy period → no gnt while busy=1, and exactly one gnt per access.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
// Imported by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_DM = 1'b1;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational winner selector for the fetch and data ports.
// Tie-break policy: fixed data priority, or round-robin when ARB_ROUND_ROBIN_EN is defined.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic dm_req,
    input  logic last_winner,
    output logic grant_if,
    output logic grant_dm
);

`ifdef ARB_ROUND_ROBIN_EN
    // On a tie, the port that did not win last time gets the grant.
    always_comb begin
        grant_if = if_req & (~dm_req | (last_winner == PORT_DM));
        grant_dm = dm_req & (~if_req | (last_winner == PORT_IF));
    end
`else
    logic unused_last_winner;
    assign unused_last_winner = last_winner;

    always_comb begin
        grant_dm = dm_req;
        grant_if = if_req & ~dm_req;
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch and data load/store.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: data port wins ties).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t              state_q, state_d;
    logic                winner_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                mem_we_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                last_winner;
    logic                grant_if, grant_dm;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_winner_q;

    // Reset to DATA so the first tie after reset goes to fetch.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_q <= PORT_DM;
        end else if (dm_gnt) begin
            last_winner_q <= PORT_DM;
        end else if (if_gnt) begin
            last_winner_q <= PORT_IF;
        end
    end

    assign last_winner = last_winner_q;
`else
    assign last_winner = PORT_DM;
`endif

    mem_arb_pick u_pick (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .last_winner (last_winner),
        .grant_if    (grant_if),
        .grant_dm    (grant_dm)
    );

    always_comb begin
        state_d = state_q;
        if_gnt  = 1'b0;
        dm_gnt  = 1'b0;
        case (state_q)
            IDLE: begin
                if_gnt = grant_if & ~rst;
                dm_gnt = grant_dm & ~rst;
                if (if_gnt | dm_gnt) begin
                    state_d = ACCESS;
                end
            end
            ACCESS:  state_d = mem_we_q ? IDLE : RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            winner_q    <= PORT_IF;
            mem_addr_q  <= '0;
            mem_we_q    <= 1'b0;
            mem_wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (dm_gnt) begin
                winner_q    <= PORT_DM;
                mem_addr_q  <= dm_addr;
                mem_we_q    <= dm_we;
                mem_wdata_q <= dm_wdata;
            end else if (if_gnt) begin
                winner_q    <= PORT_IF;
                mem_addr_q  <= if_addr;
                mem_we_q    <= 1'b0;
                mem_wdata_q <= '0;
            end
        end
    end

    // Gating with rst keeps a store from landing when reset hits its ACCESS cycle.
    assign mem_en    = (state_q == ACCESS) & ~rst;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

    assign if_rvalid = (state_q == RESP) && (winner_q == PORT_IF);
    assign dm_rvalid = (state_q == RESP) && (winner_q == PORT_DM);
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-count/transaction-level reference model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [5:0]  if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [5:0]  dm_addr;
    logic [31:0] dm_wdata;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        mem_en, mem_we;
    logic [5:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [31:0] env_mem [64];
    logic [31:0] ref_mem [64];

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    // Memory array with one-cycle registered read.
    always_ff @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) env_mem[mem_addr] <= mem_wdata;
            mem_rdata <= env_mem[mem_addr];
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One isolated transaction, started from IDLE; checks the full N..N+2 timeline.
    task automatic do_access(input logic port, input logic we,
                             input logic [5:0] addr, input logic [31:0] data);
        logic [31:0] exp_w;
        logic [31:0] exp_r;
        @(negedge clk);
        if (port == PORT_DM) begin
            dm_req = 1'b1; dm_we = we; dm_addr = addr; dm_wdata = data;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        #1;
        checks++;
        if ({if_gnt, dm_gnt} !== ((port == PORT_DM) ? 2'b01 : 2'b10) || busy !== 1'b0) begin
            errors++;
            $display("FAIL gnt: got if_gnt=%b dm_gnt=%b busy=%b, required port %0d granted, busy=0",
                     if_gnt, dm_gnt, busy, port);
        end
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0;
        #1;
        exp_w = (port == PORT_DM) ? data : 32'h0;
        checks++;
        if (mem_en !== 1'b1 || mem_addr !== addr || mem_we !== we || mem_wdata !== exp_w
            || busy !== 1'b1 || if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin
            errors++;
            $display("FAIL access: got en=%b addr=%0d we=%b wdata=%h busy=%b, required en=1 addr=%0d we=%b wdata=%h busy=1",
                     mem_en, mem_addr, mem_we, mem_wdata, busy, addr, we, exp_w);
        end
        if (!we) begin
            exp_r = ref_mem[addr];
            @(negedge clk); #1;
            checks++;
            if ({if_rvalid, dm_rvalid} !== ((port == PORT_DM) ? 2'b01 : 2'b10) || busy !== 1'b1
                || ((port == PORT_DM) ? dm_rdata : if_rdata) !== exp_r
                || ((port == PORT_DM) ? if_rdata : dm_rdata) !== 32'h0) begin
                errors++;
                $display("FAIL resp: got if_rv=%b dm_rv=%b if_rdata=%h dm_rdata=%h busy=%b, required port %0d data %h",
                         if_rvalid, dm_rvalid, if_rdata, dm_rdata, busy, port, exp_r);
            end
        end else begin
            ref_mem[addr] = data;
        end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || if_rvalid !== 1'b0 || dm_rvalid !== 1'b0 || mem_en !== 1'b0) begin
            errors++;
            $display("FAIL done: got busy=%b if_rv=%b dm_rv=%b mem_en=%b, required all 0",
                     busy, if_rvalid, dm_rvalid, mem_en);
        end
        $display("txn port=%s we=%b addr=%0d data=%h", (port == PORT_DM) ? "DM" : "IF", we, addr,
                 we ? data : ref_mem[addr]);
    endtask

    task automatic test_reset();
        logic [108:0] outs;
        @(negedge clk);
        rst = 1'b1; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b1;
        if_addr = 6'd7; dm_addr = 6'd9; dm_wdata = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (if_gnt !== 1'b0 || dm_gnt !== 1'b0) begin
            errors++;
            $display("FAIL reset_gnt: got if_gnt=%b dm_gnt=%b, required 0 0", if_gnt, dm_gnt);
        end
        @(negedge clk); #1;
        outs = {mem_en, mem_we, mem_addr, mem_wdata, busy, if_gnt, dm_gnt,
                if_rvalid, dm_rvalid, if_rdata, dm_rdata};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outs: got %h, required 0", outs);
        end
        @(negedge clk);
        rst = 1'b0; if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
        $display("txn reset");
    endtask

    task automatic test_fetch();
        do_access(PORT_DM, 1'b1, 6'd5, 32'hDEAD_BEEF);
        do_access(PORT_IF, 1'b0, 6'd5, 32'h0);
    endtask

    task automatic test_store_load();
        do_access(PORT_DM, 1'b1, 6'd10, 32'h1234_5678);
        do_access(PORT_DM, 1'b0, 6'd10, 32'h0);
    endtask

    task automatic test_tie();
        int   ng;
        int   last_g;
        logic exp_p;
        apply_reset();
        @(negedge clk);
        if_req = 1'b1; if_addr = 6'd0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 6'd1;
        ng = 0; last_g = -1;
        for (int c = 0; c < 40 && ng < 4; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (if_gnt === 1'b1 || dm_gnt === 1'b1) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp_p = (ng % 2 == 0) ? PORT_IF : PORT_DM;
`else
                exp_p = PORT_DM;
`endif
                checks++;
                if ({if_gnt, dm_gnt} !== ((exp_p == PORT_DM) ? 2'b01 : 2'b10)) begin
                    errors++;
                    $display("FAIL tie_order: grant %0d got if_gnt=%b dm_gnt=%b, required port %0d",
                             ng, if_gnt, dm_gnt, exp_p);
                end
                if (ng > 0) begin
                    checks++;
                    if (c - last_g != 3) begin
                        errors++;
                        $display("FAIL tie_spacing: got %0d cycles between grants, required 3", c - last_g);
                    end
                end
                $display("txn tie grant %0d to %s at cycle %0d", ng, dm_gnt ? "DM" : "IF", c);
                last_g = c;
                ng++;
            end
        end
        checks++;
        if (ng != 4) begin
            errors++;
            $display("FAIL tie_timeout: got %0d grants, required 4", ng);
        end
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_store();
        logic [108:0] outs;
        do_access(PORT_DM, 1'b1, 6'd3, 32'hAAAA_0000);
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 6'd3; dm_wdata = 32'h5555_5555;
        #1;
        checks++;
        if (dm_gnt !== 1'b1) begin
            errors++;
            $display("FAIL rst_store_gnt: got dm_gnt=%b, required 1", dm_gnt);
        end
        @(negedge clk);
        dm_req = 1'b0; rst = 1'b1;
        #1;
        checks++;
        if (mem_en !== 1'b0) begin
            errors++;
            $display("FAIL rst_mem_en: got mem_en=%b, required 0", mem_en);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        outs = {mem_en, mem_we, mem_addr, mem_wdata, busy, if_gnt, dm_gnt,
                if_rvalid, dm_rvalid, if_rdata, dm_rdata};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rst_idle_outs: got %h, required 0", outs);
        end
        checks++;
        if (env_mem[3] !== 32'hAAAA_0000) begin
            errors++;
            $display("FAIL rst_mem_kept: got mem[3]=%h, required aaaa0000", env_mem[3]);
        end
        $display("txn reset during store to addr 3");
        do_access(PORT_DM, 1'b0, 6'd3, 32'h0);
    endtask

    task automatic test_random(input int n_cycles);
        int          free_at, rv_cyc;
        logic        rv_port, lw;
        logic [31:0] rv_data;
        logic        ifp, dmp, dw;
        logic [5:0]  ia, da;
        logic [31:0] dd;
        logic        e_busy, e_if, e_dm, e_ifrv, e_dmrv;
        apply_reset();
        for (int i = 0; i < 64; i++) begin
            do_access(PORT_DM, 1'b1, 6'(i), $urandom);
        end
        lw = PORT_DM;
        free_at = 0; rv_cyc = -1; rv_port = PORT_IF; rv_data = 32'h0;
        ifp = 1'b0; dmp = 1'b0; dw = 1'b0; ia = '0; da = '0; dd = '0;
        for (int c = 0; c < n_cycles; c++) begin
            @(negedge clk);
            if (!ifp && $urandom_range(2) == 0) begin
                ifp = 1'b1; ia = 6'($urandom_range(63));
            end
            if (!dmp && $urandom_range(2) == 0) begin
                dmp = 1'b1; dw = 1'($urandom_range(1));
                da = 6'($urandom_range(63)); dd = $urandom;
            end
            if_req = ifp; if_addr = ia;
            dm_req = dmp; dm_we = dw; dm_addr = da; dm_wdata = dd;
            #1;
            e_busy = (c < free_at);
            e_if = 1'b0; e_dm = 1'b0;
            if (!e_busy && (ifp || dmp)) begin
                if (ifp && dmp) begin
`ifdef ARB_ROUND_ROBIN_EN
                    e_dm = (lw == PORT_IF);
`else
                    e_dm = 1'b1;
`endif
                end else begin
                    e_dm = dmp;
                end
                e_if = ~e_dm;
            end
            e_ifrv = (rv_cyc == c) && (rv_port == PORT_IF);
            e_dmrv = (rv_cyc == c) && (rv_port == PORT_DM);
            checks++;
            if (busy !== e_busy || if_gnt !== e_if || dm_gnt !== e_dm) begin
                errors++;
                $display("FAIL rnd_gnt c=%0d: got busy=%b if_gnt=%b dm_gnt=%b, required %b %b %b",
                         c, busy, if_gnt, dm_gnt, e_busy, e_if, e_dm);
            end
            checks++;
            if (if_rvalid !== e_ifrv || dm_rvalid !== e_dmrv
                || if_rdata !== (e_ifrv ? rv_data : 32'h0)
                || dm_rdata !== (e_dmrv ? rv_data : 32'h0)) begin
                errors++;
                $display("FAIL rnd_resp c=%0d: got if_rv=%b dm_rv=%b if_rdata=%h dm_rdata=%h, required %b %b data %h",
                         c, if_rvalid, dm_rvalid, if_rdata, dm_rdata, e_ifrv, e_dmrv, rv_data);
            end
            if (e_if) begin
                lw = PORT_IF;
                rv_cyc = c + 2; rv_port = PORT_IF; rv_data = ref_mem[ia];
                free_at = c + 3;
                ifp = 1'b0;
                $display("txn rnd c=%0d IF load addr=%0d data=%h", c, ia, rv_data);
            end else if (e_dm) begin
                lw = PORT_DM;
                if (dw) begin
                    ref_mem[da] = dd;
                    free_at = c + 2;
                    $display("txn rnd c=%0d DM store addr=%0d data=%h", c, da, dd);
                end else begin
                    rv_cyc = c + 2; rv_port = PORT_DM; rv_data = ref_mem[da];
                    free_at = c + 3;
                    $display("txn rnd c=%0d DM load addr=%0d data=%h", c, da, rv_data);
                end
                dmp = 1'b0;
            end
        end
        @(negedge clk);
        if_req = 1'b0; dm_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b0; if_req = 1'b0; if_addr = '0;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        test_reset();
        test_fetch();
        test_store_load();
        test_tie();
        test_reset_mid_store();
        test_random(500);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
